// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the alignment/legality helper used at request accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // True when the size encoding is illegal or the address is not naturally aligned.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// store merge of the addressed lanes into a full memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];
    load_data  = '0;
    store_word = word;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates a CPU request, performs a
// read-modify-write for subword stores and returns one response per request.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory word addressed, read data used at closing edge
// WRITE | one-cycle memory write strobe
// RESP  | response held until resp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        r_write;
  size_t       r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [31:0] hi_bits;
  logic        req_bad;
  logic        word_store;

  assign hi_bits    = req_addr >> ADDR_BITS;
  assign req_bad    = bad_access(req_size, req_addr[1:0]) || (hi_bits != '0);
  assign word_store = req_write && (req_size == SIZE_WORD);
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  lsu_lane_align u_align (
    .word       (mem_rdata),
    .size       (r_size),
    .sign_ext   (r_signed),
    .lane       (r_lane),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      r_write    <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_signed   <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= size_t'(req_size);
            r_signed   <= req_signed;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            if (req_bad) begin
              resp_error <= 1'b1;
              state      <= ST_RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (word_store) begin
                mem_wdata <= req_wdata;
                mem_write <= 1'b1;
                state     <= ST_WRITE;
              end else begin
                state <= ST_READ;
              end
            end
          end
        end
        // Subword stores reuse the read to merge their lanes into the word.
        ST_READ: begin
          if (r_write) begin
            mem_wdata <= store_word;
            mem_write <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single requests plus
// hand sequences for response back-pressure and reset during a store.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  int          wr_count = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_BITS(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'h0;

  // Memory model commits on the falling edge; contents are seeded on the first one.
  always @(negedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h01010101 * i;
      mem[8'h10] <= 32'h8899AABB;
      mem[8'hFF] <= 32'h11223344;
      mem_init   <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endfunction

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic run_vec(input vec_t v);
    int w0, lat;
    bit got;
    @(negedge clock);
    check({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
    drive_req(v.wr, v.size, v.sgn, v.addr, v.wdata);
    resp_ready = 1'b0;
    w0 = wr_count;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clock);
      lat++;
      if (!v.exp_err && lat == 1) check({v.name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      if (resp_valid) got = 1;
    end
    check({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " req_ready in resp"}, 32'(req_ready), 32'd0);
    check({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, " error"}, 32'(resp_error), 32'(v.exp_err));
    check({v.name, " write pulses"}, wr_count - w0, (v.wr && !v.exp_err) ? 1 : 0);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    check({v.name, " back to idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int w0;
    bit got;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    add("ld_b_s_41",  0, 2'b00, 1, 32'h41,  0, 32'hFFFFFFAA, 0, 2);
    add("ld_h_u_42",  0, 2'b01, 0, 32'h42,  0, 32'h00008899, 0, 2);
    add("ld_b_u_40",  0, 2'b00, 0, 32'h40,  0, 32'h000000BB, 0, 2);
    add("ld_h_s_40",  0, 2'b01, 1, 32'h40,  0, 32'hFFFFAABB, 0, 2);
    add("ld_w_40",    0, 2'b10, 1, 32'h40,  0, 32'h8899AABB, 0, 2);
    add("st_b_43",    1, 2'b00, 0, 32'h43,  32'hFFFFFF5C, 0, 0, 3);
    add("ld_w_40b",   0, 2'b10, 0, 32'h40,  0, 32'h5C99AABB, 0, 2);
    add("ld_w_mis",   0, 2'b10, 0, 32'h42,  0, 0, 1, 1);
    add("ld_h_mis",   0, 2'b01, 0, 32'h41,  0, 0, 1, 1);
    add("ld_size3",   0, 2'b11, 0, 32'h40,  0, 0, 1, 1);
    add("ld_b_oor",   0, 2'b00, 0, 32'h400, 0, 0, 1, 1);
    add("ld_b_top",   0, 2'b00, 0, 32'h3FF, 0, 32'h00000011, 0, 2);
    add("st_h_42",    1, 2'b01, 0, 32'h42,  32'h1234CAFE, 0, 0, 3);
    add("ld_h_s_42",  0, 2'b01, 1, 32'h42,  0, 32'hFFFFCAFE, 0, 2);
    add("ld_w_40c",   0, 2'b10, 0, 32'h40,  0, 32'hCAFEAABB, 0, 2);
    add("st_w_mis",   1, 2'b10, 0, 32'h12,  32'h12345678, 0, 1, 1);
    add("st_b_oor",   1, 2'b00, 0, 32'hFFFFFFFC, 32'h55, 0, 1, 1);
    add("st_b_44",    1, 2'b00, 0, 32'h44,  32'h00000080, 0, 0, 3);
    add("ld_b_s_44",  0, 2'b00, 1, 32'h44,  0, 32'hFFFFFF80, 0, 2);
    add("ld_w_44",    0, 2'b10, 0, 32'h44,  0, 32'h11111180, 0, 2);
    add("st_w_3fc",   1, 2'b10, 0, 32'h3FC, 32'hA5A5A5A5, 0, 0, 2);
    add("ld_w_3fc",   0, 2'b10, 0, 32'h3FC, 0, 32'hA5A5A5A5, 0, 2);

    repeat (3) @(negedge clock);
    check("rst req_ready",  32'(req_ready),  32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_write",  32'(mem_write),  32'd0);
    check("rst mem_addr",   mem_addr,        32'd0);
    check("rst mem_wdata",  mem_wdata,       32'd0);
    check("rst resp_rdata", resp_rdata,      32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Word store held in RESP by back-pressure for five cycles.
    @(negedge clock);
    drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    resp_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clock);
      if (resp_valid) got = 1;
    end
    check("stall resp_valid", 32'(resp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stall resp_valid held", 32'(resp_valid), 32'd1);
      check("stall req_ready", 32'(req_ready), 32'd0);
      check("stall rdata", resp_rdata, 32'd0);
      check("stall error", 32'(resp_error), 32'd0);
      check("stall mem_write", 32'(mem_write), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    check("stall idle", 32'(req_ready), 32'd1);
    check("stall resp_valid drop", 32'(resp_valid), 32'd0);
    check("stall mem word", mem[4], 32'hDEADBEEF);

    // Reset sampled at the edge ending READ of a byte store.
    @(negedge clock);
    w0 = wr_count;
    drive_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h77);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("rstw req_ready",  32'(req_ready),  32'd1);
    check("rstw resp_valid", 32'(resp_valid), 32'd0);
    check("rstw resp_rdata", resp_rdata,      32'd0);
    check("rstw resp_error", 32'(resp_error), 32'd0);
    check("rstw mem_write",  32'(mem_write),  32'd0);
    check("rstw mem_addr",   mem_addr,        32'd0);
    check("rstw mem_wdata",  mem_wdata,       32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("rstw no response", 32'(resp_valid), 32'd0);
    check("rstw write pulses", wr_count - w0, 0);
    check("rstw mem unchanged", mem[8'h10], 32'hCAFEAABB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d compares, expected completion", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_BITS, default 10, byte-address width backed by main memory; addresses >= 2**ADDR_BITS are out of range.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit accepts request; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  sign-extend subword loads when 1, zero-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; subword stores use low bits.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 resp_error  output  1  misaligned, illegal size or out-of-range request.
REQ-015 mem_addr  output  32  word-aligned address to main memory ({addr[31:2],2'b00}).
REQ-016 mem_write  output  1  write enable to main memory (memory commits on falling edge).
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  combinational read data from main memory.

Function
REQ-019 FSM states IDLE, READ, WRITE, RESP; request accepted on rising edge with req_valid & req_ready, fields captured into registers.
REQ-020 IDLE -> RESP with resp_error=1 on accept if size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= 2**ADDR_BITS; no memory access occurs.
REQ-021 IDLE -> READ for legal loads and byte/halfword stores; IDLE -> WRITE for legal word stores.
REQ-022 READ lasts one cycle; mem_rdata captured at its closing edge; load -> RESP, subword store -> WRITE.
REQ-023 WRITE lasts exactly one cycle with mem_write=1; mem_wdata = captured word with addressed lanes replaced (word store: req_wdata unchanged); -> RESP.
REQ-024 mem_write, mem_addr, mem_wdata are registered; mem_write=0 in every state but WRITE; mem_addr held stable from READ through WRITE.
REQ-025 Little-endian lanes: byte lane = addr[1:0] (bits 8*n+7:8*n); halfword lane = addr[1] (bits 16*n+15:16*n).
REQ-026 Load extraction: selected lane right-justified, sign- or zero-extended per req_signed; word loads ignore req_signed.
REQ-027 RESP holds resp_valid, resp_rdata, resp_error stable until resp_ready=1 at a rising edge, then -> IDLE; req_ready stays 0 in RESP (no overlap).
REQ-028 Latency from accept edge k: error resp_valid at k+1; load and word store at k+2; subword store at k+3.
REQ-029 resp_rdata=0 and resp_error=0 for successful stores.

Reset
REQ-030 reset_n=0 at a rising edge forces IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset has priority over all transitions; reset sampled at the edge that would enter WRITE prevents the memory write; a WRITE cycle already entered completes its falling-edge commit.
REQ-032 In-flight request is discarded on reset; no response is produced for it.

Structure
REQ-033 Shared package lsu_pkg holds size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state type.
REQ-034 Sub-module lsu_lane_align (combinational) performs load extraction/extension and store lane merge; FSM and registers stay in load_store_unit.

Verification
REQ-035 Memory word 0x40 = 0x8899AABB; load byte signed at 0x41 -> resp_rdata=0xFFFFFFAA, resp_valid at k+2.
REQ-036 Same word; load halfword unsigned at 0x42 -> resp_rdata=0x00008899.
REQ-037 Store byte 0x5C at 0x43 over 0x8899AABB -> one mem_write pulse, mem_wdata=0x5C99AABB, resp_valid at k+3; reload word -> 0x5C99AABB.
REQ-038 Load word at 0x42 -> resp_error=1 at k+1, mem_write never asserted, resp_rdata=0.
REQ-039 Store word 0xDEADBEEF at 0x10 with resp_ready held 0 for 5 cycles -> resp_valid and outputs stable, req_ready=0 throughout, IDLE after resp_ready=1.
REQ-040 Subword store with reset_n=0 at the edge ending READ -> no mem_write pulse, all outputs at reset values next cycle, memory unchanged.
